axil_apb_bridge_mslv: RTL

AXI4-Lite slave to APB (APB4) master bridge for up to 16 APB slaves, with parametrised address/data width and fixed-size address windows per slave. It has full AXI4-Lite handshakes, round-robin read/write arbitration, decode-error response for unmapped addresses, and a PREADY timeout. It sits between the AXI4-Lite interconnect and the peripheral APB segment.

---
 rtl/axil_apb_bridge_mslv_if.sv | 56 +++++
 rtl/axil_apb_bridge_mslv.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/axil_apb_bridge_mslv_if.sv
// Bus interfaces for the AXI4-Lite to APB bridge: an AXI4-Lite link and a multi-slave APB segment.
interface axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid, arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid, rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface apb_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  logic [ADDR_W-1:0]            paddr;
  logic [NUM_SLAVES-1:0]        psel;
  logic                         penable, pwrite;
  logic [DATA_W-1:0]            pwdata;
  logic [DATA_W/8-1:0]          pstrb;
  logic [2:0]                   pprot;
  logic [NUM_SLAVES-1:0]        pready;
  logic [NUM_SLAVES*DATA_W-1:0] prdata;
  logic [NUM_SLAVES-1:0]        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );
  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/axil_apb_bridge_mslv.sv
// AXI4-Lite slave to APB4 master bridge: one transaction at a time, read/write round-robin,
// fixed address windows per APB slave, decode error for unmapped windows, PREADY timeout.
module axil_apb_bridge_mslv #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int NUM_SLAVES    = 4,
  parameter int SLV_ADDR_BITS = 12,
  parameter int TIMEOUT       = 16
) (
  input logic    s_axi_clk,
  input logic    s_axi_areset,
  axil_if.slave  s_axi,
  apb_if.master  m_apb
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            prot_q;
  logic [DATA_W-1:0]     wdata_q, rdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic                  wr_q, last_wr_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [1:0]            resp_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  wr_req, rd_req, grant_wr, grant_rd, grant;
  logic [ADDR_W-1:0]     g_addr;
  logic [3:0]            g_idx;
  logic                  g_dec_err;
  logic [NUM_SLAVES-1:0] g_sel;
  logic                  sel_ready, sel_err, timeout_hit, resp_done;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  aw_rdy, ar_rdy;

  // Request decode and arbitration; a write needs address and data in the same cycle.
  always_comb begin
    wr_req    = s_axi.awvalid && s_axi.wvalid;
    rd_req    = s_axi.arvalid;
    grant_wr  = wr_req && !(rd_req && last_wr_q);
    grant_rd  = rd_req && !grant_wr;
    grant     = grant_wr || grant_rd;
    g_addr    = grant_wr ? s_axi.awaddr : s_axi.araddr;
    g_idx     = g_addr[SLV_ADDR_BITS +: 4];
    g_dec_err = ({1'b0, g_idx} >= 5'(NUM_SLAVES));
    g_sel     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) g_sel[i] = (g_idx == 4'(i));
    // Only the selected slave's response lines are observed.
    sel_ready = |(m_apb.pready & sel_q);
    sel_err   = |(m_apb.pslverr & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_q[i]) sel_rdata = sel_rdata | m_apb.prdata[i*DATA_W +: DATA_W];
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    resp_done   = wr_q ? s_axi.bready : s_axi.rready;
  end

  always_comb begin
    state_nx = state;
    aw_rdy   = 1'b0;
    ar_rdy   = 1'b0;
    case (state)
      IDLE: if (grant) begin
        aw_rdy   = grant_wr;
        ar_rdy   = grant_rd;
        state_nx = g_dec_err ? RESP : SETUP;
      end
      SETUP:  state_nx = ACCESS;
      ACCESS: if (sel_ready || timeout_hit) state_nx = RESP;
      RESP:   if (resp_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state     <= IDLE;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      strb_q    <= '0;
      wr_q      <= 1'b0;
      last_wr_q <= 1'b1;  // makes the first contended grant go to the read side
      sel_q     <= '0;
      resp_q    <= OKAY;
      cnt_q     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (grant) begin
          wr_q      <= grant_wr;
          last_wr_q <= grant_wr;
          addr_q    <= g_addr;
          prot_q    <= grant_wr ? s_axi.awprot : s_axi.arprot;
          wdata_q   <= grant_wr ? s_axi.wdata : '0;
          strb_q    <= grant_wr ? s_axi.wstrb : '0;
          sel_q     <= g_dec_err ? '0 : g_sel;
          resp_q    <= g_dec_err ? DECERR : OKAY;
          rdata_q   <= '0;
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (sel_ready) begin
            rdata_q <= sel_rdata;
            resp_q  <= sel_err ? SLVERR : OKAY;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            resp_q  <= SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = aw_rdy;
  assign s_axi.arready = ar_rdy;
  assign s_axi.bvalid  = (state == RESP) && wr_q;
  assign s_axi.rvalid  = (state == RESP) && !wr_q;
  assign s_axi.bresp   = resp_q;
  assign s_axi.rresp   = resp_q;
  assign s_axi.rdata   = rdata_q;

  // psel/penable come straight from state so an async reset drops them at once.
  assign m_apb.psel    = (state == SETUP || state == ACCESS) ? sel_q : '0;
  assign m_apb.penable = (state == ACCESS);
  assign m_apb.paddr   = addr_q;
  assign m_apb.pwrite  = wr_q;
  assign m_apb.pwdata  = wdata_q;
  assign m_apb.pstrb   = strb_q;
  assign m_apb.pprot   = prot_q;
endmodule
